// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: board front end for the cpu step input.
// It debounces the KEY pushbutton and gives one step pulse per accepted press.
// In run mode it produces free-running step pulses at a divided rate instead.
// It also keeps a count of every step pulse it issues.
// There is a single clock domain. Both raw inputs are synchronised before they are used.
module step_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,  // stable cycles to accept a level change, >= 2
    parameter int RUN_DIV         = 5000000, // cycles between run-mode pulses, >= 2
    parameter int CNT_W           = 16       // width of step_count
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             key_n,
    input  logic             run_switch,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count,
    output logic             key_level,
    output logic             run_active
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    // Debounce states.
    // The high level is accepted only after DEBOUNCE_CYCLES stable cycles in PRESS_WAIT.
    // The low level is accepted only after DEBOUNCE_CYCLES stable cycles in RELEASE_WAIT.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_t;

    // The key is synchronised in pressed polarity.
    // The reset value of the flops therefore means "not pressed".
    // This avoids a phantom press when reset is released.
    logic key_meta_q, key_sync_q;
    logic run_meta_q, run_sync_q;
    logic pressed_s;

    db_state_t        state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             press_fire;
    logic             run_fire;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= 1'b0;
            key_sync_q <= 1'b0;
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
        end else begin
            key_meta_q <= ~key_n;
            key_sync_q <= key_meta_q;
            run_meta_q <= run_switch;
            run_sync_q <= run_meta_q;
        end
    end

    assign pressed_s  = key_sync_q;
    assign run_active = run_sync_q;

    // Debounce FSM state and its shared stability counter
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            db_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Next-state logic.
    // The counter restarts on every state change.
    // press_fire marks the accepted press, which is the transition from PRESS_WAIT to PRESSED.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = '0;
        press_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed_s) state_d = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = ST_PRESSED;
                    press_fire = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = ST_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_level = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

    // Run-rate divider.
    // It is held at zero outside run mode, so dropping the switch mid-count abandons the period.
    always_comb begin
        div_cnt_d = '0;
        run_fire  = 1'b0;
        if (run_active) begin
            if (div_cnt_q == DIV_LAST) begin
                run_fire = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Pulse selection.
    // Manual presses count only outside run mode, and the divider fires only inside it.
    // The two sources are therefore mutually exclusive.
    always_comb begin
        pulse_d = (press_fire && !run_active) || run_fire;
        count_d = count_q + CNT_W'(pulse_q);
    end

    // Divider, registered step pulse and wrapping step counter
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
        end
    end

    assign step_pulse = pulse_q;
    assign step_count = count_q;

endmodule
